riscv_dmem_bridge: RTL

//  Data-memory bridge directly downstream of the CPU core's load/store port.

---
 rtl/riscv_dmem_pkg.sv | 18 +
 rtl/riscv_dmem_wbuf.sv | 49 ++++
 rtl/riscv_dmem_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the data-memory bridge (riscv_dmem_bridge).
package riscv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  localparam logic [31:0] DEAD_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/riscv_dmem_wbuf.sv
// One-entry posted-write buffer; used by riscv_dmem_bridge only when RISCV_DMEM_WBUF_EN is defined.
module riscv_dmem_wbuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o
);

  logic        vld_q, vld_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop_i) begin
      vld_d = 1'b0;
    end
    // A push is only honoured into an empty slot; the bridge stalls the core otherwise.
    if (push_i && !vld_q) begin
      vld_d  = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/riscv_dmem_bridge.sv
// Core load/store port to req/gnt/rvalid bus bridge with timeout and sticky error.
// Optional posted writes through a one-entry buffer when RISCV_DMEM_WBUF_EN is defined.
module riscv_dmem_bridge
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] DEAD_DATA      = DEAD_DATA_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_rden_i,
  input  logic        cpu_wren_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_data_av_o,
  output logic        cpu_busy_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  localparam bit               TMO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  dmem_state_t      state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;
  logic             bus_req, data_av, busy;

`ifdef RISCV_DMEM_WBUF_EN
  logic        wbuf_push, wbuf_pop, wbuf_full;
  logic [31:0] wbuf_addr, wbuf_data;

  riscv_dmem_wbuf u_wbuf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (wbuf_push),
    .addr_i (word_addr(cpu_addr_i)),
    .data_i (cpu_wdata_i),
    .pop_i  (wbuf_pop),
    .full_o (wbuf_full),
    .addr_o (wbuf_addr),
    .data_o (wbuf_data)
  );

  // Every bus write is a buffer drain; the slot is freed once it is granted or aborted.
  assign wbuf_pop = (state_q == REQ) && we_q && (bus_gnt_i || tmo_hit);
`endif

  assign tmo_hit = TMO_EN && (cnt_q == TMO_VAL) &&
                   ((state_q == REQ) || (state_q == WAIT_R));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    bus_req = 1'b0;
    data_av = 1'b0;
    busy    = 1'b0;
`ifdef RISCV_DMEM_WBUF_EN
    wbuf_push = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef RISCV_DMEM_WBUF_EN
        if (wbuf_full) begin
          busy    = cpu_rden_i | cpu_wren_i;
          addr_d  = wbuf_addr;
          wdata_d = wbuf_data;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end else if (cpu_wren_i) begin
          wbuf_push = 1'b1;
          if (cpu_rden_i) begin
            err_d = 1'b1;
          end
        end else if (cpu_rden_i) begin
          busy    = 1'b1;
          addr_d  = word_addr(cpu_addr_i);
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
`else
        busy = cpu_rden_i | cpu_wren_i;
        if (cpu_rden_i || cpu_wren_i) begin
          addr_d  = word_addr(cpu_addr_i);
          wdata_d = cpu_wdata_i;
          // A simultaneous read is dropped in favour of the write and flagged.
          we_d    = cpu_wren_i;
          cnt_d   = '0;
          state_d = REQ;
          if (cpu_rden_i && cpu_wren_i) begin
            err_d = 1'b1;
          end
        end
`endif
      end
      REQ: begin
        busy  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit) begin
          err_d = 1'b1;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rdata_d = DEAD_DATA;
            state_d = RESP;
          end
        end else begin
          bus_req = 1'b1;
          if (bus_gnt_i) begin
            state_d = we_q ? IDLE : WAIT_R;
          end
        end
      end
      WAIT_R: begin
        busy  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = DEAD_DATA;
          state_d = RESP;
        end else if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        data_av = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_rdata_o   = rdata_q;
  assign cpu_data_av_o = data_av;
  assign cpu_busy_o    = busy;
  assign bus_req_o     = bus_req;
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  // The timeout cycle itself already reports the error, before the sticky flag lands.
  assign err_o         = err_q | tmo_hit;

endmodule
